// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and slot-map constants for the slave return-path mux.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } hresp_e;

    typedef enum logic {
        DS_IDLE = 1'b0,
        DS_ERR2 = 1'b1
    } ds_state_e;

    localparam int NSLV     = 8;
    localparam int DEF_SLOT = 6;

endpackage

// File: rtl/ahb_slave_mux_if.sv
// Bus bundle between decoder/slaves and the return-path mux.
interface ahb_slave_mux_if #(
    parameter int DW   = 32,
    parameter int NSLV = ahb_pkg::NSLV,
    parameter int AW   = 34
);
    logic [NSLV-1:0]    HSEL;
    logic [AW-1:0]      HADDR;
    logic [1:0]         HTRANS;
    logic [NSLV*DW-1:0] HRDATA_S;
    logic [NSLV-1:0]    HREADYOUT_S;
    logic [NSLV-1:0]    HRESP_S;
    logic [DW-1:0]      HRDATA;
    logic               HREADY;
    logic               HRESP;

    // The mux sits on the slave side of this bundle.
    modport slave (
        input  HSEL, HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        output HRDATA, HREADY, HRESP
    );

    modport master (
        output HSEL, HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        input  HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_default_slave.sv
// Built-in default slave: two-cycle ERROR for active transfers, plus error counter
// and last-faulting-address capture.
module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int AW  = 34,
    parameter int ECW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cur_hit,
    input  logic           next_hit,
    input  logic           addr_load,
    input  logic [AW-1:0]  haddr,
    output logic           hready,
    output logic           hresp,
    output logic [ECW-1:0] err_cnt,
    output logic [AW-1:0]  err_addr
);

    ds_state_e      state_reg;
    logic           hready_reg;
    logic           hresp_reg;
    logic [ECW-1:0] err_cnt_reg;
    logic [AW-1:0]  err_addr_reg;
    logic [AW-1:0]  ahold_reg;

    // Outputs are registered: each edge computes what the next data phase must
    // see from the next state and the select/transfer type captured at this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= DS_IDLE;
            hready_reg   <= 1'b1;
            hresp_reg    <= OKAY;
            err_cnt_reg  <= '0;
            err_addr_reg <= '0;
            ahold_reg    <= '0;
        end else begin
            if (addr_load)
                ahold_reg <= haddr;

            if (state_reg == DS_ERR2) begin
                state_reg    <= DS_IDLE;
                err_addr_reg <= ahold_reg;
                if (err_cnt_reg != '1)
                    err_cnt_reg <= err_cnt_reg + 1'b1;
            end else if (cur_hit) begin
                state_reg <= DS_ERR2;
            end

            if (state_reg == DS_IDLE && cur_hit) begin
                hready_reg <= 1'b1;
                hresp_reg  <= ERROR;
            end else if (next_hit) begin
                hready_reg <= 1'b0;
                hresp_reg  <= ERROR;
            end else begin
                hready_reg <= 1'b1;
                hresp_reg  <= OKAY;
            end
        end
    end

    assign hready   = hready_reg;
    assign hresp    = hresp_reg;
    assign err_cnt  = err_cnt_reg;
    assign err_addr = err_addr_reg;

endmodule

// File: rtl/ahb_slave_mux.sv
// AHB-Lite slave-to-master return mux: registers decoder selects per address phase
// and routes the selected slave (or the internal default slave) to the master.
module ahb_slave_mux #(
    parameter int DW       = 32,
    parameter int NSLV     = ahb_pkg::NSLV,
    parameter int DEF_SLOT = ahb_pkg::DEF_SLOT,
    parameter int AW       = 34,
    parameter int ECW      = 8
) (
    input  logic           HCLK,
    input  logic           HRESET,
    ahb_slave_mux_if.slave bus,
    output logic [ECW-1:0] ERR_CNT,
    output logic [AW-1:0]  ERR_ADDR
);

    localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam logic [SW-1:0] DEF_IDX = SW'(DEF_SLOT);

    logic          dsel_vld_reg, dsel_vld_next;
    logic [SW-1:0] dsel_reg, dsel_next, sel_enc;
    logic          dact_reg, dact_next;
    logic          active;
    logic          cur_hit, next_hit, addr_load;
    logic          ds_hready, ds_hresp;
    logic          hready_mux, hresp_mux;
    logic [DW-1:0] hrdata_mux;
    logic [DW-1:0] slot_rdata [NSLV];

    for (genvar gi = 0; gi < NSLV; gi++) begin : g_slot
        assign slot_rdata[gi] = bus.HRDATA_S[gi*DW +: DW];
    end

    // Lowest set select wins when the decoder drives more than one bit.
    always_comb begin
        sel_enc = '0;
        for (int i = NSLV - 1; i >= 0; i--)
            if (bus.HSEL[i]) sel_enc = SW'(i);
    end

    assign active = (bus.HTRANS == ahb_pkg::NONSEQ) || (bus.HTRANS == ahb_pkg::SEQ);

    always_comb begin
        dsel_vld_next = dsel_vld_reg;
        dsel_next     = dsel_reg;
        dact_next     = dact_reg;
        if (hready_mux) begin
            dsel_vld_next = |bus.HSEL;
            dsel_next     = sel_enc;
            dact_next     = active;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dsel_vld_reg <= 1'b0;
            dsel_reg     <= '0;
            dact_reg     <= 1'b0;
        end else begin
            dsel_vld_reg <= dsel_vld_next;
            dsel_reg     <= dsel_next;
            dact_reg     <= dact_next;
        end
    end

    assign addr_load = hready_mux && bus.HSEL[DEF_SLOT] && active;
    assign cur_hit   = dsel_vld_reg && (dsel_reg == DEF_IDX) && dact_reg;
    assign next_hit  = dsel_vld_next && (dsel_next == DEF_IDX) && dact_next;

    ahb_default_slave #(
        .AW  (AW),
        .ECW (ECW)
    ) u_default_slave (
        .clk       (HCLK),
        .rst       (HRESET),
        .cur_hit   (cur_hit),
        .next_hit  (next_hit),
        .addr_load (addr_load),
        .haddr     (bus.HADDR),
        .hready    (ds_hready),
        .hresp     (ds_hresp),
        .err_cnt   (ERR_CNT),
        .err_addr  (ERR_ADDR)
    );

    always_comb begin
        hready_mux = 1'b1;
        hresp_mux  = ahb_pkg::OKAY;
        hrdata_mux = '0;
        if (dsel_vld_reg) begin
            if (dsel_reg == DEF_IDX) begin
                hready_mux = ds_hready;
                hresp_mux  = ds_hresp;
            end else begin
                hready_mux = bus.HREADYOUT_S[dsel_reg];
                hresp_mux  = bus.HRESP_S[dsel_reg];
                hrdata_mux = slot_rdata[dsel_reg];
            end
        end
    end

    assign bus.HREADY = hready_mux;
    assign bus.HRESP  = hresp_mux;
    assign bus.HRDATA = hrdata_mux;

    // Multi-hot selects are tolerated but worth noticing in simulation.
    assert property (@(posedge HCLK) disable iff (HRESET) hready_mux |-> $onehot0(bus.HSEL))
        else $warning("ahb_slave_mux: multiple HSEL bits set (%b), lowest index used", bus.HSEL);

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Directed bench for ahb_slave_mux with a queue of expected data-phase completions.
module tb_ahb_slave_mux;
    import ahb_pkg::*;

    localparam int DW  = 32;
    localparam int NS  = 8;
    localparam int AW  = 34;
    localparam int ECW = 8;

    typedef struct packed {
        logic [DW-1:0] hrdata;
        logic          hresp;
    } exp_t;

    logic           HCLK   = 1'b0;
    logic           HRESET = 1'b0;
    logic [ECW-1:0] err_cnt;
    logic [AW-1:0]  err_addr;
    int             n_checks = 0;
    int             n_errors = 0;
    exp_t           sb[$];

    ahb_slave_mux_if #(.DW(DW), .NSLV(NS), .AW(AW)) bus ();

    ahb_slave_mux #(
        .DW(DW), .NSLV(NS), .DEF_SLOT(6), .AW(AW), .ECW(ECW)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .bus      (bus.slave),
        .ERR_CNT  (err_cnt),
        .ERR_ADDR (err_addr)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no summary after 1ms, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_idle();
        bus.HSEL   = '0;
        bus.HTRANS = IDLE;
        bus.HADDR  = '0;
    endtask

    task automatic drive_addr(input logic [NS-1:0] sel, input logic [1:0] trans,
                              input logic [AW-1:0] addr, input logic [DW-1:0] exp_data,
                              input logic exp_resp);
        exp_t e;
        bus.HSEL   = sel;
        bus.HTRANS = trans;
        bus.HADDR  = addr;
        e.hrdata   = exp_data;
        e.hresp    = exp_resp;
        sb.push_back(e);
    endtask

    // Called at a negedge where the data phase is expected to complete.
    task automatic complete(input string tag);
        exp_t e;
        check({tag, "_ready"}, bus.HREADY, 1'b1);
        n_checks++;
        assert (sb.size() > 0) else begin
            n_errors++;
            $error("FAIL %s_sb: observed empty queue expected pending transfer", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, bus.HRDATA, e.hrdata);
            check({tag, "_resp"}, bus.HRESP, e.hresp);
        end
    endtask

    function automatic logic [AW-1:0] sat_addr(input int i);
        return 34'h1_0000_0000 + AW'(i * 4);
    endfunction

    initial begin
        drive_idle();
        bus.HRDATA_S    = '0;
        bus.HREADYOUT_S = '1;
        bus.HRESP_S     = '0;
        bus.HRDATA_S[3*DW +: DW] = 32'h3333_0003;
        bus.HRDATA_S[7*DW +: DW] = 32'h7777_0007;
        #1 HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_ready", bus.HREADY, 1'b1);
        check("rst_resp", bus.HRESP, 1'b0);
        check("rst_data", bus.HRDATA, '0);
        check("rst_cnt", err_cnt, '0);
        check("rst_addr", err_addr, '0);
        @(posedge HCLK);
        #1 HRESET = 1'b0;

        // Single read from slot 0 with two wait states
        bus.HRDATA_S[0 +: DW] = 32'hDEAD_BEEF;
        drive_addr(8'h01, NONSEQ, 34'h0_0000_0100, 32'hDEAD_BEEF, 1'b0);
        tick();
        drive_idle();
        bus.HREADYOUT_S[0] = 1'b0;
        @(negedge HCLK); check("rd0_wait1", bus.HREADY, 1'b0);
        tick();
        @(negedge HCLK); check("rd0_wait2", bus.HREADY, 1'b0);
        tick();
        bus.HREADYOUT_S[0] = 1'b1;
        @(negedge HCLK); complete("rd0");
        tick();

        // Unmapped access hits the default slave
        drive_addr(8'h40, NONSEQ, 34'h0_2000_0000, 32'h0, 1'b1);
        tick();
        drive_idle();
        @(negedge HCLK); check("unmap_c1", {bus.HREADY, bus.HRESP}, 2'b01);
        tick();
        @(negedge HCLK); complete("unmap_c2");
        tick();
        @(negedge HCLK);
        check("unmap_cnt", err_cnt, 8'd1);
        check("unmap_addr", err_addr, 34'h0_2000_0000);

        // IDLE transfer to the default slot is a zero-wait OKAY
        drive_addr(8'h40, IDLE, 34'h3_0000_0000, 32'h0, 1'b0);
        tick();
        drive_idle();
        @(negedge HCLK); complete("idle6");
        check("idle6_cnt", err_cnt, 8'd1);
        tick();
        @(negedge HCLK); check("idle6_addr", err_addr, 34'h0_2000_0000);

        // Slot 3 stalls while slot 7 waits in the address phase
        drive_addr(8'h08, NONSEQ, 34'h0_3000_0000, 32'h3333_0003, 1'b0);
        tick();
        bus.HREADYOUT_S[3] = 1'b0;
        bus.HREADYOUT_S[7] = 1'b0;
        drive_addr(8'h80, NONSEQ, 34'h0_7000_0000, 32'h7777_0007, 1'b1);
        @(negedge HCLK); check("sw_stall1", bus.HREADY, 1'b0);
        tick();
        @(negedge HCLK);
        check("sw_stall2", bus.HREADY, 1'b0);
        check("sw_hold3", bus.HRDATA, 32'h3333_0003);
        tick();
        bus.HREADYOUT_S[3] = 1'b1;
        @(negedge HCLK); complete("sw_s3");
        tick();
        drive_idle();
        bus.HRESP_S[7] = 1'b1;
        @(negedge HCLK); check("sw_s7_err1", {bus.HREADY, bus.HRESP}, 2'b01);
        tick();
        bus.HREADYOUT_S[7] = 1'b1;
        @(negedge HCLK); complete("sw_s7");
        tick();
        bus.HRESP_S[7] = 1'b0;

        // Back-to-back errors until the counter saturates
        drive_addr(8'h40, NONSEQ, sat_addr(0), 32'h0, 1'b1);
        tick();
        for (int i = 0; i < 260; i++) begin
            if (i < 259) drive_addr(8'h40, NONSEQ, sat_addr(i + 1), 32'h0, 1'b1);
            else         drive_idle();
            @(negedge HCLK); check($sformatf("sat%0d_c1", i), {bus.HREADY, bus.HRESP}, 2'b01);
            tick();
            @(negedge HCLK); complete($sformatf("sat%0d_c2", i));
            tick();
        end
        @(negedge HCLK);
        check("sat_cnt", err_cnt, 8'hFF);
        check("sat_addr", err_addr, sat_addr(259));
        check("sat_after", {bus.HREADY, bus.HRESP}, 2'b10);
        tick();

        // Reset asserted during the ERR2 cycle
        bus.HSEL   = 8'h40;
        bus.HTRANS = NONSEQ;
        bus.HADDR  = 34'h2_AAAA_0000;
        tick();
        drive_idle();
        @(negedge HCLK); check("rstm_c1", {bus.HREADY, bus.HRESP}, 2'b01);
        tick();
        check("rstm_err2", {bus.HREADY, bus.HRESP}, 2'b11);
        #2 HRESET = 1'b1;
        #1;
        check("rstm_ready", bus.HREADY, 1'b1);
        check("rstm_resp", bus.HRESP, 1'b0);
        check("rstm_cnt", err_cnt, '0);
        check("rstm_addr", err_addr, '0);
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK); check("rstm_post1", {bus.HREADY, bus.HRESP}, 2'b10);
        tick();
        @(negedge HCLK);
        check("rstm_post2", {bus.HREADY, bus.HRESP}, 2'b10);
        check("rstm_cnt2", err_cnt, '0);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
